// File: rtl/led_fade_pwm.sv
// ---------------------------------------------------------------------------
// led_fade_pwm
//   Four-channel LED driver that fades each channel toward its on/off target
//   with a PWM duty ramp instead of switching it hard.
//
//   Parameters
//     PWM_BITS  : duty / PWM counter width, full scale FS = 2^PWM_BITS-1
//     STEP_CYC  : clock cycles between fade steps (1 .. 2^20)
//     FADE_STEP : duty change applied per fade step (1 .. FS)
//
//   Ports
//     clk      : system clock, all state on rising edge
//     rst_n    : asynchronous active-low reset
//     led_on   : [3:0] target pattern from the upstream water-light stage
//     fade_en  : 1 = ramp duty gradually, 0 = snap duty to target
//     led_out  : [3:0] registered PWM pins, 1 = lit
//     busy     : registered, 1 while any channel duty differs from target
// ---------------------------------------------------------------------------

// Per-channel duty ramp and PWM output stage.
//   tgt      : registered target bit (1 = full scale, 0 = off)
//   tick     : fade step strobe shared by all channels
//   pwm_cnt  : shared free-running PWM phase
//   duty     : current duty level
//   led_out  : registered PWM pin
//   mismatch : combinational duty != target, feeds the shared busy flag
module led_fade_lane #(
    parameter int PWM_BITS  = 8,
    parameter int FADE_STEP = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tgt,
    input  logic                fade_en,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] duty,
    output logic                led_out,
    output logic                mismatch
);
    localparam logic [PWM_BITS-1:0] FS     = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS:0]   STEP_W = (PWM_BITS+1)'(FADE_STEP);

    logic [PWM_BITS-1:0] target;
    logic [PWM_BITS-1:0] duty_nxt;
    logic [PWM_BITS:0]   up_w;
    logic [PWM_BITS:0]   dn_w;

    always_comb begin
        target   = tgt ? FS : '0;
        // One extra bit so the step can never wrap: carry out of up_w means
        // overshoot past FS, borrow into the top bit of dn_w means below 0.
        up_w     = {1'b0, duty} + STEP_W;
        dn_w     = {1'b0, duty} - STEP_W;
        duty_nxt = duty;
        if (!fade_en) begin
            duty_nxt = target;
        end else if (tick) begin
            if (duty < target)
                duty_nxt = (up_w > {1'b0, FS}) ? FS : up_w[PWM_BITS-1:0];
            else if (duty > target)
                duty_nxt = dn_w[PWM_BITS] ? '0 : dn_w[PWM_BITS-1:0];
        end
        mismatch = (duty != target);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty    <= '0;
            led_out <= 1'b0;
        end else begin
            duty <= duty_nxt;
            // Full scale and zero are forced so the pin is steady at the
            // extremes rather than glitching once per PWM period.
            if (duty == FS)
                led_out <= 1'b1;
            else if (duty == '0)
                led_out <= 1'b0;
            else
                led_out <= (pwm_cnt < duty);
        end
    end
endmodule

module led_fade_pwm #(
    parameter int PWM_BITS  = 8,
    parameter int STEP_CYC  = 1000,
    parameter int FADE_STEP = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] led_on,
    input  logic       fade_en,
    output logic [3:0] led_out,
    output logic       busy
);
    localparam int NUM_LANES = 4;
    localparam int SCW       = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam logic [SCW-1:0] STEP_LAST = SCW'(STEP_CYC - 1);

    logic [NUM_LANES-1:0]               tgt;
    logic [PWM_BITS-1:0]                pwm_cnt;
    logic [SCW-1:0]                     step_cnt;
    logic                               tick;
    logic [NUM_LANES-1:0][PWM_BITS-1:0] duty;
    logic [NUM_LANES-1:0]               mismatch;

    // With STEP_CYC = 1 step_cnt is pinned at 0 and tick is always high.
    assign tick = (step_cnt == STEP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt      <= '0;
            pwm_cnt  <= '0;
            step_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            tgt      <= led_on;
            pwm_cnt  <= pwm_cnt + 1'b1;   // natural wrap FS -> 0
            step_cnt <= tick ? '0 : step_cnt + 1'b1;
            busy     <= |mismatch;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        led_fade_lane #(
            .PWM_BITS  (PWM_BITS),
            .FADE_STEP (FADE_STEP)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .tgt      (tgt[i]),
            .fade_en  (fade_en),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt),
            .duty     (duty[i]),
            .led_out  (led_out[i]),
            .mismatch (mismatch[i])
        );
    end
endmodule

// File: tb/tb_led_fade_pwm.sv
module tb_led_fade_pwm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] led_on = 4'b1111;
    logic       fade_en = 1'b0;
    logic [3:0] led_out;
    logic       busy;

    // Second instance with a long step period so a mid duty is held long
    // enough to observe a full PWM period.
    logic       rst2_n = 1'b0;
    logic [3:0] led2_on = 4'b0010;
    logic       fade2_en = 1'b1;
    logic [3:0] led2_out;
    logic       busy2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    led_fade_pwm #(.PWM_BITS(4), .STEP_CYC(2), .FADE_STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .led_on(led_on), .fade_en(fade_en),
        .led_out(led_out), .busy(busy)
    );

    led_fade_pwm #(.PWM_BITS(4), .STEP_CYC(40), .FADE_STEP(8)) dut2 (
        .clk(clk), .rst_n(rst2_n), .led_on(led2_on), .fade_en(fade2_en),
        .led_out(led2_out), .busy(busy2)
    );

    typedef struct {
        logic [3:0] led_on;
        logic       fe;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] led;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] lo, input logic fe, input logic [3:0] d0,
                       input logic [3:0] d1, input logic [3:0] led, input logic b);
        vec_t v;
        v.led_on = lo; v.fe = fe; v.d0 = d0; v.d1 = d1; v.led = led; v.busy = b;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit hit;

        // edge-by-edge after reset release: {led_on, fade_en, duty0, duty1, led_out, busy}
        // snap on, snap off
        add(4'b0001,0, 0, 0,4'b0000,0); add(4'b0001,0,15, 0,4'b0000,1);
        add(4'b0001,0,15, 0,4'b0001,0); add(4'b0001,0,15, 0,4'b0001,0);
        add(4'b0000,0,15, 0,4'b0001,0); add(4'b0000,0, 0, 0,4'b0001,1);
        add(4'b0000,0, 0, 0,4'b0000,0);
        // fade up 4,8,12,15 on even edges, busy drops one edge after 15
        add(4'b0001,1, 0, 0,4'b0000,0); add(4'b0001,1, 0, 0,4'b0000,1);
        add(4'b0001,1, 4, 0,4'b0000,1); add(4'b0001,1, 4, 0,4'b0000,1);
        add(4'b0001,1, 8, 0,4'b0000,1); add(4'b0001,1, 8, 0,4'b0000,1);
        add(4'b0001,1,12, 0,4'b0000,1); add(4'b0001,1,12, 0,4'b0000,1);
        add(4'b0001,1,15, 0,4'b0000,1); add(4'b0001,1,15, 0,4'b0001,0);
        add(4'b0001,1,15, 0,4'b0001,0);
        // fade down to 7, then reverse back up from 7
        add(4'b0000,1,15, 0,4'b0001,0); add(4'b0000,1,11, 0,4'b0001,1);
        add(4'b0000,1,11, 0,4'b0001,1); add(4'b0000,1, 7, 0,4'b0001,1);
        add(4'b0001,1, 7, 0,4'b0001,1); add(4'b0001,1,11, 0,4'b0000,1);
        add(4'b0001,1,11, 0,4'b0001,1); add(4'b0001,1,15, 0,4'b0001,1);
        add(4'b0001,1,15, 0,4'b0001,0);
        // water shift ch0 -> ch1, both step in the same tick, ch0 clamps at 0
        add(4'b0010,1,15, 0,4'b0001,0); add(4'b0010,1,15, 0,4'b0001,1);
        add(4'b0010,1,11, 4,4'b0001,1); add(4'b0010,1,11, 4,4'b0000,1);
        add(4'b0010,1, 7, 8,4'b0000,1); add(4'b0010,1, 7, 8,4'b0011,1);
        add(4'b0010,1, 3,12,4'b0011,1); add(4'b0010,1, 3,12,4'b0011,1);
        add(4'b0010,1, 0,15,4'b0010,1); add(4'b0010,1, 0,15,4'b0010,0);
        add(4'b0010,1, 0,15,4'b0010,0);
        // shift back, then drop fade_en mid-fade: snap without corruption
        add(4'b0001,1, 0,15,4'b0010,0); add(4'b0001,1, 4,11,4'b0010,1);
        add(4'b0001,0,15, 0,4'b0010,1); add(4'b0001,0,15, 0,4'b0001,0);

        // reset is asynchronous: outputs clear without a clock edge
        repeat (2) @(negedge clk);
        check("reset_led", {12'd0, led_out}, 16'h0000);
        check("reset_busy", {15'd0, busy}, 16'h0000);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("pre_reset_led", {12'd0, led_out}, 16'h000f);
        #2 rst_n = 1'b0;
        #1 check("async_reset_led", {12'd0, led_out}, 16'h0000);
        check("async_reset_busy", {15'd0, busy}, 16'h0000);
        check("async_reset_duty", 16'(dut.duty), 16'h0000);
        led_on = 4'b0000;
        @(negedge clk) rst_n = 1'b1;

        foreach (tbl[i]) begin
            led_on  = tbl[i].led_on;
            fade_en = tbl[i].fe;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_duty0", i + 1), {12'd0, dut.duty[0]}, {12'd0, tbl[i].d0});
            check($sformatf("v%0d_duty1", i + 1), {12'd0, dut.duty[1]}, {12'd0, tbl[i].d1});
            check($sformatf("v%0d_led", i + 1), {12'd0, led_out}, {12'd0, tbl[i].led});
            check($sformatf("v%0d_busy", i + 1), {15'd0, busy}, {15'd0, tbl[i].busy});
        end

        // reset mid-fade while ch1 is at 8, then fade restarts from 0
        led_on = 4'b0010;
        fade_en = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(posedge clk);
            #1 hit = (dut.duty[1] == 4'd8);
        end
        check("midfade_reach8", {15'd0, hit}, 16'h0001);
        #2 rst_n = 1'b0;
        #1 check("midfade_rst_led", {12'd0, led_out}, 16'h0000);
        check("midfade_rst_busy", {15'd0, busy}, 16'h0000);
        check("midfade_rst_duty", 16'(dut.duty), 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("restart_e1_duty1", {12'd0, dut.duty[1]}, 16'd0);
        check("restart_e1_busy", {15'd0, busy}, 16'h0000);
        @(posedge clk);
        #1 check("restart_e2_duty1", {12'd0, dut.duty[1]}, 16'd4);
        check("restart_e2_busy", {15'd0, busy}, 16'h0001);
        check("restart_e2_duty0", {12'd0, dut.duty[0]}, 16'd0);

        // long step period: first tick at edge 40, duty 8 gives 8/16 high
        @(negedge clk) rst2_n = 1'b1;
        repeat (39) @(posedge clk);
        #1 check("dut2_e39_duty1", {12'd0, dut2.duty[1]}, 16'd0);
        @(posedge clk);
        #1 check("dut2_e40_duty1", {12'd0, dut2.duty[1]}, 16'd8);
        cnt = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1 if (led2_out[1]) cnt++;
        end
        check("dut2_pwm_high_count", 16'(cnt), 16'd8);
        check("dut2_busy", {15'd0, busy2}, 16'h0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/led_fade_pwm.md
LED_FADE_PWM -- requirements
Module: led_fade_pwm

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8: duty/PWM counter width; full-scale duty FS = 2^PWM_BITS-1.
REQ-002 SHALL have parameter STEP_CYC, default 1000: clock cycles between fade steps; legal range 1 to 2^20.
REQ-003 SHALL have parameter FADE_STEP, default 5: duty increment/decrement per fade step; legal range 1 to FS.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port led_on, input, 4 bits: target on/off pattern from the upstream water-light stage, synchronous to clk.
REQ-007 SHALL have port fade_en, input, 1 bit: 1 = gradual fade; 0 = immediate snap.
REQ-008 SHALL have port led_out, output, 4 bits: PWM-driven LED pins, 1 = lit.
REQ-009 SHALL have port busy, output, 1 bit: 1 while any channel duty differs from its target.

Function
REQ-010 SHALL register led_on into tgt[3:0] every cycle; target duty T[i] = FS if tgt[i]=1, else 0.
REQ-011 SHALL run a free-running pwm_cnt of PWM_BITS bits, incrementing every cycle and wrapping FS->0.
REQ-012 SHALL run step_cnt 0..STEP_CYC-1, wrapping to 0; tick = 1 for exactly one cycle when step_cnt = STEP_CYC-1 (every cycle when STEP_CYC=1).
REQ-013 SHALL hold per-channel duty[i], PWM_BITS wide, updated only as in REQ-014..REQ-016.
REQ-014 With fade_en=1 and tick=1: if duty[i]<T[i], duty[i] SHALL become min(duty[i]+FADE_STEP, FS); if duty[i]>T[i], it SHALL become max(duty[i]-FADE_STEP, 0); the computation SHALL be one bit wider than PWM_BITS so it never wraps.
REQ-015 With fade_en=1 and tick=0, duty[i] SHALL hold.
REQ-016 With fade_en=0, duty[i] SHALL load T[i] on the next rising edge regardless of tick.
REQ-017 A target change mid-fade SHALL reverse direction on the next tick from the current duty; no restart from 0 or FS.
REQ-018 led_out[i] SHALL be registered: 1 if duty[i]=FS; 0 if duty[i]=0; otherwise (pwm_cnt < duty[i]).
REQ-019 busy SHALL be registered and equal OR over i of (duty[i] != T[i]) as computed from the previous cycle's state.
REQ-020 Latency: a led_on change SHALL reach tgt after 1 edge; with fade_en=0, duty after 2 edges and led_out after 3 edges.
REQ-021 Fade time 0->FS SHALL be ceil(FS/FADE_STEP) ticks.
REQ-022 Channels SHALL be independent; simultaneous rising and falling channels SHALL step in the same tick.
REQ-023 fade_en toggling mid-fade SHALL take effect on the next edge without corrupting duty.

Reset
REQ-024 On rst_n=0, asynchronously: tgt=0, duty[i]=0, pwm_cnt=0, step_cnt=0, led_out=4'b0000, busy=0.
REQ-025 After rst_n deasserts, the first step_cnt increment and first tick SHALL be counted from that first active edge; reset mid-fade SHALL discard all fade progress.

Verification
REQ-026 Bench configuration: PWM_BITS=4 (FS=15), STEP_CYC=2, FADE_STEP=4.
REQ-027 Scenario, reset: rst_n=0 with led_on=4'b1111 -> led_out=0 and busy=0 immediately, without waiting for a clk edge.
REQ-028 Scenario, snap: fade_en=0, led_on 0000->0001 -> duty[0]=15 two edges later; led_out[0]=1 constantly from the third edge.
REQ-029 Scenario, fade up: fade_en=1, led_on=0001 held -> duty[0] goes 4, 8, 12, 15 on successive ticks (saturates, no wrap); busy falls one cycle after duty reaches 15.
REQ-030 Scenario, reversal: fade_en=1, led_on=0001 until duty[0]=8, then 0000 -> duty[0] goes 4, then 0 (saturates at 0).
REQ-031 Scenario, water shift: led_on 0001->0010 with fade_en=1 -> on each tick ch0 decreases and ch1 increases by 4 in the same cycle; at duty=8, led_out high for 8 of 16 cycles.
REQ-032 Scenario, async reset mid-fade: rst_n pulsed low while duty[1]=8 -> all duty 0, led_out 0000; after release, fade restarts from 0.
